// File: rtl/register_bus_responder.sv
// Register bank that sits on a shared bus: captures bus_in on request, drives a register back out, and flags protocol errors.
// Optional: define REG_BANK_R0_ZERO_EN to make register 0 read as zero and discard its writes.
module register_bus_responder #(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_REGS   = 5
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [5:0]            register_addr,
  input  logic                  bus_register_input_en,
  input  logic                  bus_register_out_en,
  input  logic [DATA_WIDTH-1:0] bus_in,
  input  logic                  error_clear,
  output logic [DATA_WIDTH-1:0] bus_out,
  output logic                  bus_out_en,
  output logic                  write_ack,
  output logic                  addr_error,
  output logic                  bus_conflict
);

  localparam int         IDX_W        = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [6:0] NUM_REGS_EXT = 7'(NUM_REGS);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    DRIVE   = 2'd2,
    HOLD    = 2'd3
  } state_e;

  state_e                  state_q, state_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic                    write_ack_q, write_ack_d;
  logic                    addr_error_q, addr_error_d;
  logic                    bus_conflict_q, bus_conflict_d;
  logic [DATA_WIDTH-1:0]   regs_q [NUM_REGS];

  logic                    addr_legal;
  logic [IDX_W-1:0]        addr_idx;
  logic                    do_write;
  logic                    reg_we;
  logic                    conflict_set;
  logic                    addr_err_set;
  logic [DATA_WIDTH-1:0]   rd_data;

  assign addr_legal = ({1'b0, register_addr} < NUM_REGS_EXT);
  assign addr_idx   = register_addr[IDX_W-1:0];

  // NOTE: every variable assigned here gets a default first, so no path can leave it unassigned and infer a latch.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    do_write     = 1'b0;
    conflict_set = 1'b0;
    addr_err_set = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus_register_input_en && bus_register_out_en) begin
          conflict_set = 1'b1;
          addr_err_set = !addr_legal;
          state_d      = HOLD;
        end else if (bus_register_input_en || bus_register_out_en) begin
          if (!addr_legal) begin
            addr_err_set = 1'b1;
            state_d      = HOLD;
          end else begin
            idx_d = addr_idx;
            if (bus_register_input_en) begin
              do_write = 1'b1;
              state_d  = CAPTURE;
            end else begin
              state_d  = DRIVE;
            end
          end
        end
      end
      CAPTURE: if (!bus_register_input_en) state_d = IDLE;
      DRIVE:   if (!bus_register_out_en)   state_d = IDLE;
      HOLD:    if (!bus_register_input_en && !bus_register_out_en) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // A flag raised in the same cycle as error_clear wins over the clear.
  always_comb begin
    write_ack_d    = do_write;
    addr_error_d   = addr_err_set ? 1'b1 : (error_clear ? 1'b0 : addr_error_q);
    bus_conflict_d = conflict_set ? 1'b1 : (error_clear ? 1'b0 : bus_conflict_q);
  end

`ifdef REG_BANK_R0_ZERO_EN
  assign reg_we = do_write && (addr_idx != '0);
`else
  assign reg_we = do_write;
`endif

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q        <= IDLE;
      idx_q          <= '0;
      write_ack_q    <= 1'b0;
      addr_error_q   <= 1'b0;
      bus_conflict_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      idx_q          <= idx_d;
      write_ack_q    <= write_ack_d;
      addr_error_q   <= addr_error_d;
      bus_conflict_q <= bus_conflict_d;
    end
  end

  // NOTE: the bank is built from flops (not RAM) because reset must clear every register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else if (reg_we) begin
      regs_q[addr_idx] <= bus_in;
    end
  end

  always_comb begin
    rd_data = regs_q[idx_q];
`ifdef REG_BANK_R0_ZERO_EN
    if (idx_q == '0) rd_data = '0;
`endif
  end

  // Drive enable comes straight from state so an async reset drops it immediately.
  assign bus_out_en   = (state_q == DRIVE);
  assign bus_out      = bus_out_en ? rd_data : '0;
  assign write_ack    = write_ack_q;
  assign addr_error   = addr_error_q;
  assign bus_conflict = bus_conflict_q;

endmodule

// File: tb/tb_register_bus_responder.sv
// Scoreboard bench for register_bus_responder: stimulus pushes expected reads/acks, a negedge monitor pops and compares.
module tb_register_bus_responder;

  localparam int DW = 16;
  localparam int NR = 5;

  logic          clock = 1'b0;
  logic          reset;
  logic [5:0]    register_addr;
  logic          bus_register_input_en;
  logic          bus_register_out_en;
  logic [DW-1:0] bus_in;
  logic          error_clear;
  logic [DW-1:0] bus_out;
  logic          bus_out_en;
  logic          write_ack;
  logic          addr_error;
  logic          bus_conflict;

  register_bus_responder #(.DATA_WIDTH(DW), .NUM_REGS(NR)) dut (
    .clock                 (clock),
    .reset                 (reset),
    .register_addr         (register_addr),
    .bus_register_input_en (bus_register_input_en),
    .bus_register_out_en   (bus_register_out_en),
    .bus_in                (bus_in),
    .error_clear           (error_clear),
    .bus_out               (bus_out),
    .bus_out_en            (bus_out_en),
    .write_ack             (write_ack),
    .addr_error            (addr_error),
    .bus_conflict          (bus_conflict)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] exp_rd_q [$];
  int            exp_ack_q [$];
  logic [DW-1:0] model [NR];

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  // Monitor: every output beat is matched against the scoreboard.
  initial begin
    forever begin
      @(negedge clock);
      if (reset) begin
        check("ack_vs_drive_exclusive", {31'd0, write_ack && bus_out_en}, 32'd0);
        if (write_ack) begin
          if (exp_ack_q.size() == 0) check("unexpected_write_ack", 32'd1, 32'd0);
          else void'(exp_ack_q.pop_front());
        end
        if (bus_out_en) begin
          if (exp_rd_q.size() == 0) check("unexpected_bus_out_en", 32'd1, 32'd0);
          else check("bus_out_data", {16'd0, bus_out}, {16'd0, exp_rd_q.pop_front()});
        end else begin
          check("bus_out_zero_when_idle", {16'd0, bus_out}, 32'd0);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic void model_write(input int a, input logic [DW-1:0] d);
    if (a < NR) begin
`ifdef REG_BANK_R0_ZERO_EN
      if (a != 0) model[a] = d;
`else
      model[a] = d;
`endif
    end
  endfunction

  task automatic write_req(input int a, input logic [DW-1:0] d);
    tick();
    register_addr = 6'(a);
    bus_in = d;
    bus_register_input_en = 1'b1;
    exp_ack_q.push_back(a);
    model_write(a, d);
    tick();
    bus_register_input_en = 1'b0;
  endtask

  task automatic read_req(input int a, input int n);
    tick();
    register_addr = 6'(a);
    bus_register_out_en = 1'b1;
    repeat (n) exp_rd_q.push_back(model[a]);
    repeat (n) tick();
    bus_register_out_en = 1'b0;
  endtask

  task automatic read_all();
    for (int i = 0; i < NR; i++) read_req(i, 1);
  endtask

  initial begin
    reset = 1'b0;
    register_addr = '0;
    bus_register_input_en = 1'b0;
    bus_register_out_en = 1'b0;
    bus_in = '0;
    error_clear = 1'b0;
    for (int i = 0; i < NR; i++) model[i] = '0;

    #12;
    check("reset_bus_out",      {16'd0, bus_out}, 32'd0);
    check("reset_bus_out_en",   {31'd0, bus_out_en}, 32'd0);
    check("reset_write_ack",    {31'd0, write_ack}, 32'd0);
    check("reset_addr_error",   {31'd0, addr_error}, 32'd0);
    check("reset_bus_conflict", {31'd0, bus_conflict}, 32'd0);
    #2 reset = 1'b1;

    write_req(2, 16'h00A5);
    read_req(2, 1);
    write_req(4, 16'h1234);
    read_req(4, 3);
    write_req(0, 16'hFFFF);
    read_req(0, 1);
    write_req(1, 16'h0011);
    write_req(3, 16'h0033);

    // Conflict: no write, no drive, sticky flag until cleared.
    tick();
    register_addr = 6'd1;
    bus_in = 16'hBEEF;
    bus_register_input_en = 1'b1;
    bus_register_out_en = 1'b1;
    tick();
    bus_register_input_en = 1'b0;
    bus_register_out_en = 1'b0;
    #1;
    check("conflict_flag_set", {31'd0, bus_conflict}, 32'd1);
    check("conflict_no_addr_error", {31'd0, addr_error}, 32'd0);
    tick();
    error_clear = 1'b1;
    tick();
    error_clear = 1'b0;
    #1;
    check("conflict_flag_cleared", {31'd0, bus_conflict}, 32'd0);
    read_req(1, 1);

    // Address and data changes while capturing are ignored.
    tick();
    register_addr = 6'd3;
    bus_in = 16'hABCD;
    bus_register_input_en = 1'b1;
    exp_ack_q.push_back(3);
    model_write(3, 16'hABCD);
    tick();
    register_addr = 6'd2;
    bus_in = 16'h1111;
    tick();
    tick();
    bus_register_input_en = 1'b0;
    read_req(3, 1);
    read_req(2, 1);

    // Address change while driving is ignored.
    tick();
    register_addr = 6'd4;
    bus_register_out_en = 1'b1;
    repeat (3) exp_rd_q.push_back(model[4]);
    tick();
    register_addr = 6'd3;
    tick();
    tick();
    bus_register_out_en = 1'b0;

    // Illegal address write: flag only, nothing stored.
    tick();
    register_addr = 6'd6;
    bus_in = 16'h5A5A;
    bus_register_input_en = 1'b1;
    tick();
    bus_register_input_en = 1'b0;
    #1;
    check("illegal_addr_error_set", {31'd0, addr_error}, 32'd1);
    tick();
    // First out-of-range address with error_clear in the same cycle: the set wins.
    tick();
    register_addr = 6'd5;
    bus_register_out_en = 1'b1;
    error_clear = 1'b1;
    tick();
    bus_register_out_en = 1'b0;
    error_clear = 1'b0;
    #1;
    check("set_beats_clear", {31'd0, addr_error}, 32'd1);
    tick();
    tick();
    error_clear = 1'b1;
    tick();
    error_clear = 1'b0;
    #1;
    check("addr_error_cleared", {31'd0, addr_error}, 32'd0);
    read_all();

    // Reset in the middle of a drive.
    tick();
    register_addr = 6'd4;
    bus_register_out_en = 1'b1;
    repeat (2) exp_rd_q.push_back(model[4]);
    tick();
    tick();
    tick();
    reset = 1'b0;
    #1;
    check("reset_drops_bus_out_en", {31'd0, bus_out_en}, 32'd0);
    check("reset_zeroes_bus_out", {16'd0, bus_out}, 32'd0);
    bus_register_out_en = 1'b0;
    #2 reset = 1'b1;
    for (int i = 0; i < NR; i++) model[i] = '0;
    read_all();

    repeat (4) tick();
    check("read_scoreboard_drained", exp_rd_q.size(), 32'd0);
    check("ack_scoreboard_drained", exp_ack_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
